// File: rtl/gpu_pkg.sv
// Shared GPU definitions: command field widths, SPI receiver state encoding,
// the host status byte layout and the opcode map used by the core decoder.
package gpu_pkg;

    localparam int OP_W    = 8;
    localparam int DATA_W  = 16;
    localparam int FRAME_W = OP_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } spi_state_t;

    typedef struct packed {
        logic       ovf;
        logic       abort;
        logic [1:0] rsvd;
        logic [3:0] frame_cnt;
    } status_t;

    localparam logic [OP_W-1:0] OP_NOP        = 8'h00;
    localparam logic [OP_W-1:0] OP_SET_REG    = 8'h01;
    localparam logic [OP_W-1:0] OP_SET_COLOR  = 8'h02;
    localparam logic [OP_W-1:0] OP_MOVE_TO    = 8'h10;
    localparam logic [OP_W-1:0] OP_LINE_TO    = 8'h11;
    localparam logic [OP_W-1:0] OP_FILL_RECT  = 8'h20;
    localparam logic [OP_W-1:0] OP_CLEAR      = 8'h30;
    localparam logic [OP_W-1:0] OP_SWAP       = 8'h40;

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer for asynchronous pin inputs, with a
// selectable reset value so idle-high signals come out of reset inactive.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_cmd_rx.sv
// Mode-0 SPI command receiver: oversampled pins, 24-bit frame capture into a
// one-entry valid/ready slot, and a status byte returned to the host on MISO.
module spi_cmd_rx #(
    parameter int OP_W        = 8,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [OP_W-1:0]   cmd_op,
    output logic [DATA_W-1:0] cmd_data
);

    import gpu_pkg::*;

    localparam int FRAME_BITS = OP_W + DATA_W;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    logic sclk_s, cs_n_s, mosi_s;
    logic sclk_d, cs_n_d;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    spi_state_t state_q, state_d;
    logic frame_start, frame_done, frame_abort, slot_load;

    logic [CNT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-1:0] shift_q, shift_next;
    logic [7:0]            miso_sr;
    logic                  ovf_q, abort_q;
    logic [3:0]            frame_cnt_q;
    status_t               status_snap;

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(spi_sclk), .q(sclk_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
        .clk(clk), .rst_n(rst_n), .d(spi_cs_n), .q(cs_n_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_d <= 1'b0;
            cs_n_d <= 1'b1;
        end else begin
            sclk_d <= sclk_s;
            cs_n_d <= cs_n_s;
        end
    end

    assign sclk_rise  = sclk_s & ~sclk_d;
    assign sclk_fall  = ~sclk_s & sclk_d;
    assign cs_fall    = ~cs_n_s & cs_n_d;
    assign cs_rise    = cs_n_s & ~cs_n_d;
    assign shift_next = {shift_q[FRAME_BITS-2:0], mosi_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        frame_done  = 1'b0;
        frame_abort = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d     = SHIFT;
                    frame_start = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d     = IDLE;
                    frame_abort = 1'b1;
                end else if (sclk_rise && bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                    state_d    = HOLD;
                    frame_done = 1'b1;
                end
            end
            HOLD: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A completed frame may take the slot when it is empty or being drained this cycle.
    assign slot_load   = frame_done && (!cmd_valid || cmd_ready);
    assign status_snap = '{ovf: ovf_q, abort: abort_q, rsvd: 2'b00, frame_cnt: frame_cnt_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= '0;
            shift_q     <= '0;
            miso_sr     <= '0;
            ovf_q       <= 1'b0;
            abort_q     <= 1'b0;
            frame_cnt_q <= 4'd0;
            cmd_valid   <= 1'b0;
            cmd_op      <= '0;
            cmd_data    <= '0;
        end else begin
            if (frame_start) begin
                bit_cnt <= '0;
            end else if (state_q == SHIFT && sclk_rise) begin
                shift_q <= shift_next;
                bit_cnt <= bit_cnt + 1'b1;
            end

            // Zero fill means MISO goes quiet on its own once the status byte is out.
            if (frame_start) begin
                miso_sr <= status_snap;
            end else if (cs_rise) begin
                miso_sr <= '0;
            end else if (state_q != IDLE && sclk_fall) begin
                miso_sr <= {miso_sr[6:0], 1'b0};
            end

            if (frame_start) begin
                ovf_q   <= 1'b0;
                abort_q <= 1'b0;
            end else begin
                if (frame_abort) begin
                    abort_q <= 1'b1;
                end
                if (frame_done && !slot_load) begin
                    ovf_q <= 1'b1;
                end
            end

            if (slot_load) begin
                cmd_valid   <= 1'b1;
                cmd_op      <= shift_next[FRAME_BITS-1 -: OP_W];
                cmd_data    <= shift_next[DATA_W-1:0];
                frame_cnt_q <= frame_cnt_q + 4'd1;
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end
        end
    end

    assign spi_miso    = miso_sr[7];
    assign spi_miso_oe = ~cs_n_s;

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Randomized scoreboard bench for spi_cmd_rx: a host-level model predicts
// delivered commands and status bytes; a monitor checks every accepted command.
module tb_spi_cmd_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        cmd_ready = 1'b0;
    logic        spi_miso, spi_miso_oe, cmd_valid;
    logic [7:0]  cmd_op;
    logic [15:0] cmd_data;

    int tests_run = 0;
    int tests_failed = 0;

    logic [23:0] exp_q[$];
    bit          m_ovf, m_abort, m_slot_full, m_ready;
    int          m_cnt;

    spi_cmd_rx #(.OP_W(8), .DATA_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every accepted command must match the oldest predicted one.
    always @(negedge clk) begin
        if (rst_n && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_cmd: got 0x%0h, expected no command", {cmd_op, cmd_data});
            end else begin
                checkOutput("cmd_word", {8'h00, cmd_op, cmd_data}, {8'h00, exp_q.pop_front()});
            end
        end
    end

    task automatic setReady(input bit r);
        tick();
        cmd_ready = r;
        m_ready   = r;
        if (r) m_slot_full = 1'b0;
        repeat (4) tick();
    endtask

    task automatic applyReset();
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_cmd_valid", cmd_valid, 0);
        checkOutput("rst_cmd_op", cmd_op, 0);
        checkOutput("rst_cmd_data", cmd_data, 0);
        checkOutput("rst_spi_miso", spi_miso, 0);
        checkOutput("rst_spi_miso_oe", spi_miso_oe, 0);
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        repeat (5) tick();
        rst_n = 1'b1;
        m_ovf = 0; m_abort = 0; m_slot_full = 0; m_cnt = 0;
        exp_q.delete();
        repeat (5) tick();
    endtask

    // One host frame of nbits SCLK pulses at clk/8; reads the status byte back from MISO.
    task automatic applyStimulus(input logic [23:0] word, input int nbits, input bit lat_chk, input bit rst_mid);
        logic [7:0] exp_status, got_status;
        int         miso_ones;
        exp_status = {m_ovf, m_abort, 2'b00, 4'(m_cnt)};
        m_ovf = 0;
        m_abort = 0;
        got_status = '0;
        miso_ones = 0;
        tick();
        spi_cs_n = 1'b0;
        spi_mosi = word[23];
        repeat (4) tick();
        checkOutput("miso_oe_active", spi_miso_oe, 1);
        for (int i = 0; i < nbits; i++) begin
            if (i < 8) got_status = {got_status[6:0], spi_miso};
            else if (spi_miso) miso_ones++;
            spi_sclk = 1'b1;
            if (i == 23) begin
                if (!m_slot_full || m_ready) begin
                    exp_q.push_back(word);
                    m_cnt = (m_cnt + 1) % 16;
                    m_slot_full = !m_ready;
                end else begin
                    m_ovf = 1;
                end
                if (lat_chk) begin
                    @(posedge clk);
                    @(posedge clk);
                    #1;
                    checkOutput("latency_e0p1_valid", cmd_valid, 0);
                    @(posedge clk);
                    #1;
                    checkOutput("latency_e0p2_valid", cmd_valid, 1);
                end
            end
            repeat (4) tick();
            spi_sclk = 1'b0;
            if (i < 23) spi_mosi = word[22-i];
            else spi_mosi = 1'($urandom_range(0, 1));
            repeat (4) tick();
        end
        if (nbits >= 8) checkOutput("status_byte", got_status, exp_status);
        if (nbits > 8) checkOutput("miso_tail_zero", miso_ones, 0);
        if (rst_mid) begin
            applyReset();
        end else begin
            tick();
            spi_cs_n = 1'b1;
            if (nbits < 24) m_abort = 1;
            repeat (20) tick();
            checkOutput("miso_oe_idle", spi_miso_oe, 0);
            checkOutput("miso_idle", spi_miso, 0);
        end
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        m_ovf = 0; m_abort = 0; m_slot_full = 0; m_ready = 0; m_cnt = 0;
        applyReset();

        setReady(1);
        applyStimulus(24'hA51234, 24, 1, 0);

        applyReset();
        setReady(0);
        applyStimulus(24'h010001, 24, 0, 0);
        applyStimulus(24'h020002, 24, 0, 0);
        checkOutput("held_valid", cmd_valid, 1);
        checkOutput("held_op", cmd_op, 32'h01);
        checkOutput("held_data", cmd_data, 32'h0001);
        setReady(1);
        applyStimulus(24'h030003, 24, 0, 0);
        applyStimulus(24'h040004, 24, 0, 0);

        applyStimulus(24'hBEEF01, 10, 0, 0);
        checkOutput("abort_no_valid", cmd_valid, 0);
        applyStimulus(24'h050005, 24, 0, 0);

        applyReset();
        for (int f = 0; f < 17; f++) applyStimulus(24'($urandom), 24, 0, 0);
        applyStimulus(24'h060006, 24, 0, 0);

        applyStimulus(24'($urandom), 30, 0, 0);

        applyStimulus(24'hC0FFEE, 12, 0, 1);
        applyStimulus(24'h7E5A11, 24, 0, 0);
        applyStimulus(24'h112233, 24, 0, 0);

        for (int f = 0; f < 25; f++) begin
            int r, nb;
            if ($urandom_range(0, 3) == 0) setReady(1'($urandom_range(0, 1)));
            r = $urandom_range(0, 9);
            if (r == 7) nb = $urandom_range(1, 23);
            else if (r == 8) nb = $urandom_range(25, 30);
            else nb = 24;
            applyStimulus(24'($urandom), nb, 0, 0);
        end

        setReady(1);
        repeat (10) tick();
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
